// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS.cc up/down stopwatch with prescaler, sticky done/overflow flags.
// Define STOPWATCH_LAP_EN to build the lap buffer; otherwise lap and lap_cnt read 0.
module stopwatch_core #(
    parameter int P_CLK_HZ    = 50_000_000,
    parameter int P_TICK_HZ   = 100,
    parameter int P_LAP_DEPTH = 4
) (
    input  logic                           clk1,
    input  logic                           rst_n,
    input  logic                           start_stop,
    input  logic                           lap_clr,
    input  logic                           mode,
    input  logic [23:0]                    preset,
    input  logic [$clog2(P_LAP_DEPTH)-1:0] lap_sel,
    output logic [23:0]                    time_bcd,
    output logic [23:0]                    lap,
    output logic [$clog2(P_LAP_DEPTH):0]   lap_cnt,
    output logic                           run,
    output logic                           done,
    output logic                           ovf
);
    localparam int DIV = P_CLK_HZ / P_TICK_HZ;
    localparam int PW = $clog2(DIV);
    localparam int AW = $clog2(P_LAP_DEPTH);
    localparam logic [23:0] LIM = 24'h595999;
    logic [PW-1:0] pre;
    logic mode_r, dn, tick, clr, carry;
    logic [23:0] nxt;
    // Mode is latched while stopped, so the live input governs start and clear decisions.
    always_comb begin
        dn = run ? mode_r : mode;
        tick = run && (pre == PW'(DIV - 1));
        clr = lap_clr && !start_stop && !run;
        nxt = time_bcd;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nxt[i*4 +: 4] = !carry ? time_bcd[i*4 +: 4] :
                dn ? (time_bcd[i*4 +: 4] == 4'd0 ? LIM[i*4 +: 4] : time_bcd[i*4 +: 4] - 4'd1) :
                     (time_bcd[i*4 +: 4] == LIM[i*4 +: 4] ? 4'd0 : time_bcd[i*4 +: 4] + 4'd1);
            carry = carry && (dn ? time_bcd[i*4 +: 4] == 4'd0 : time_bcd[i*4 +: 4] == LIM[i*4 +: 4]);
        end
    end
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            mode_r <= 1'b0;
            time_bcd <= '0;
            run <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
        end else begin
            pre <= (tick || !run) ? '0 : pre + PW'(1);
            if (!run) mode_r <= mode;
            if (start_stop) run <= !run && !(dn && time_bcd == '0);
            if (tick) begin
                time_bcd <= nxt;
                if (!dn && carry) ovf <= 1'b1;
                if (dn && nxt == '0) begin
                    run <= 1'b0;
                    done <= 1'b1;
                end
            end
            if (clr) begin
                time_bcd <= dn ? preset : '0;
                done <= 1'b0;
                ovf <= 1'b0;
            end
        end
    end
`ifdef STOPWATCH_LAP_EN
    logic [23:0] laps [P_LAP_DEPTH];
    logic lap_ev;
    assign lap_ev = lap_clr && !start_stop && run && lap_cnt < (AW+1)'(P_LAP_DEPTH);
    // Entries beyond lap_cnt read as 0 so a clear hides stale laps without wiping storage.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_LAP_DEPTH; i++) laps[i] <= '0;
            lap_cnt <= '0;
            lap <= '0;
        end else begin
            if (clr) lap_cnt <= '0;
            else if (lap_ev) begin
                laps[lap_cnt[AW-1:0]] <= time_bcd;
                lap_cnt <= lap_cnt + (AW+1)'(1);
            end
            lap <= ({1'b0, lap_sel} < lap_cnt) ? laps[lap_sel] : '0;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = ^lap_sel;
    assign lap = '0;
    assign lap_cnt = '0;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed checks of stopwatch_core at 1 kHz clock, 100 Hz tick (divisor 10).
// Lap expectations follow STOPWATCH_LAP_EN: real entries when defined, constant 0 otherwise.
module tb_stopwatch_core;
    logic clk1 = 1'b0;
    logic rst_n = 1'b1;
    logic start_stop = 1'b0, lap_clr = 1'b0, mode = 1'b0;
    logic [23:0] preset = '0;
    logic [1:0] lap_sel = '0;
    logic [23:0] time_bcd, lap;
    logic [2:0] lap_cnt;
    logic run, done, ovf;
    int checks = 0, errors = 0;
    logic [23:0] exp_laps [4] = '{24'h000003, 24'h000006, 24'h000009, 24'h000012};

    stopwatch_core #(.P_CLK_HZ(1000), .P_TICK_HZ(100), .P_LAP_DEPTH(4)) dut (
        .clk1(clk1), .rst_n(rst_n), .start_stop(start_stop), .lap_clr(lap_clr),
        .mode(mode), .preset(preset), .lap_sel(lap_sel), .time_bcd(time_bcd),
        .lap(lap), .lap_cnt(lap_cnt), .run(run), .done(done), .ovf(ovf)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic pulse(input logic ss, input logic lc);
        start_stop = ss;
        lap_clr = lc;
        @(negedge clk1);
        start_stop = 1'b0;
        lap_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_time"}, 32'(time_bcd), 0);
        check({tag, "_lap"}, 32'(lap), 0);
        check({tag, "_cnt"}, 32'(lap_cnt), 0);
        check({tag, "_run"}, 32'(run), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);
        check_all_zero("post_reset");

        // basic up count, then stop and freeze
        pulse(1, 0);
        wait_cyc(100);
        check("up_time", 32'(time_bcd), 32'h000010);
        check("up_run", 32'(run), 1);
        pulse(1, 0);
        check("stop_run", 32'(run), 0);
        check("stop_time", 32'(time_bcd), 32'h000010);
        wait_cyc(50);
        check("frozen_time", 32'(time_bcd), 32'h000010);

        // up-count wrap from 59:59.98
        mode = 1'b1;
        preset = 24'h595998;
        pulse(0, 1);
        check("preset_load", 32'(time_bcd), 32'h595998);
        mode = 1'b0;
        pulse(1, 0);
        wait_cyc(10);
        check("pre_wrap", 32'(time_bcd), 32'h595999);
        check("pre_wrap_ovf", 32'(ovf), 0);
        wait_cyc(10);
        check("wrap_time", 32'(time_bcd), 0);
        check("wrap_ovf", 32'(ovf), 1);
        check("wrap_run", 32'(run), 1);
        pulse(1, 0);

        // countdown to zero
        mode = 1'b1;
        preset = 24'h000005;
        pulse(0, 1);
        check("dn_load", 32'(time_bcd), 32'h000005);
        check("dn_ovf_clr", 32'(ovf), 0);
        pulse(1, 0);
        wait_cyc(45);
        check("dn_mid", 32'(time_bcd), 32'h000001);
        check("dn_mid_run", 32'(run), 1);
        wait_cyc(5);
        check("dn_zero", 32'(time_bcd), 0);
        check("dn_run", 32'(run), 0);
        check("dn_done", 32'(done), 1);
        pulse(1, 0);
        check("dn_restart_ign", 32'(run), 0);
        wait_cyc(20);
        check("dn_still_zero", 32'(time_bcd), 0);

        // laps 30 cycles apart, fifth dropped
        mode = 1'b0;
        pulse(0, 1);
        check("clr_done", 32'(done), 0);
        check("clr_time", 32'(time_bcd), 0);
        pulse(1, 0);
        wait_cyc(30);
        for (int k = 0; k < 5; k++) begin
            pulse(0, 1);
`ifdef STOPWATCH_LAP_EN
            check($sformatf("lap_cnt%0d", k), 32'(lap_cnt), (k < 4) ? k + 1 : 4);
`else
            check($sformatf("lap_cnt%0d", k), 32'(lap_cnt), 0);
`endif
            if (k < 4) wait_cyc(29);
        end
        for (int k = 0; k < 4; k++) begin
            lap_sel = 2'(k);
            wait_cyc(1);
`ifdef STOPWATCH_LAP_EN
            check($sformatf("lap_entry%0d", k), 32'(lap), 32'(exp_laps[k]));
`else
            check($sformatf("lap_entry%0d", k), 32'(lap), 0);
`endif
        end

        // start_stop wins over lap_clr
        pulse(1, 1);
        check("prio_run", 32'(run), 0);
`ifdef STOPWATCH_LAP_EN
        check("prio_cnt", 32'(lap_cnt), 4);
`else
        check("prio_cnt", 32'(lap_cnt), 0);
`endif
        check("prio_time", 32'(time_bcd), 32'h000015);
        lap_sel = 2'd0;
        pulse(0, 1);
        wait_cyc(1);
        check("clr2_cnt", 32'(lap_cnt), 0);
        check("clr2_time", 32'(time_bcd), 0);
        check("clr2_lap", 32'(lap), 0);

        // asynchronous reset mid-run
        pulse(1, 0);
        wait_cyc(20);
        pulse(0, 1);
`ifdef STOPWATCH_LAP_EN
        check("run2_cnt", 32'(lap_cnt), 1);
`else
        check("run2_cnt", 32'(lap_cnt), 0);
`endif
        wait_cyc(17);
        check("run2_time", 32'(time_bcd), 32'h000003);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk1);
        rst_n = 1'b1;
        wait_cyc(30);
        check("after_rst_run", 32'(run), 0);
        check("after_rst_time", 32'(time_bcd), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 The block SHALL have parameter P_CLK_HZ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter P_TICK_HZ, default 100, meaning count resolution in Hz (100 = centiseconds); P_CLK_HZ/P_TICK_HZ SHALL be an integer >= 2.
REQ-003 The block SHALL have parameter P_LAP_DEPTH, default 4, meaning lap buffer entries (power of 2, >= 2).
REQ-004 The block SHALL use one clock, CLK1 (input, 1 bit), and all flops SHALL be clocked on its rising edge.
REQ-005 The block SHALL use reset RST_N (input, 1 bit), which is asynchronous and active-low.
REQ-006 The block SHALL have I_START_STOP (input, 1 bit), a single-cycle pulse that toggles the run state.
REQ-007 The block SHALL have I_LAP_CLR (input, 1 bit), a single-cycle pulse that records a lap while running and clears while stopped.
REQ-008 The block SHALL have I_MODE (input, 1 bit), where 0 = count up and 1 = count down; it SHALL be sampled only while stopped.
REQ-009 The block SHALL have I_PRESET (input, 24 bits), the BCD MM:SS.cc value loaded by a clear in down mode.
REQ-010 The block SHALL have I_LAP_SEL (input, clog2(P_LAP_DEPTH) bits), the lap read index.
REQ-011 The block SHALL have O_TIME (output, 24 bits), the live BCD time as {M1,M0,S1,S0,C1,C0}, 4 bits each.
REQ-012 The block SHALL have O_LAP (output, 24 bits), the lap entry selected by I_LAP_SEL.
REQ-013 The block SHALL have O_LAP_CNT (output, clog2(P_LAP_DEPTH)+1 bits), the number of stored laps.
REQ-014 The block SHALL have O_RUN (output, 1 bit), the run state, and O_DONE (output, 1 bit), a sticky countdown-complete flag.
REQ-015 The block SHALL have O_OVF (output, 1 bit), a sticky flag indicating up-count wrap-around.

Function
REQ-016 The prescaler SHALL count 0..P_CLK_HZ/P_TICK_HZ-1 while O_RUN=1 and assert an internal tick for one cycle at its terminal value.
REQ-017 The prescaler SHALL be held at 0 while stopped, so the first tick occurs exactly P_CLK_HZ/P_TICK_HZ cycles after a start pulse.
REQ-018 In up mode, each tick SHALL increment O_TIME in BCD: cc 00-99, ss 00-59, mm 00-59, with carries propagating within the same cycle.
REQ-019 In up mode, a tick at 59:59.99 SHALL wrap the time to 00:00.00, set O_OVF=1, and keep the block running.
REQ-020 In down mode, each tick SHALL decrement O_TIME with borrows.
REQ-021 In down mode, when O_TIME reaches 00:00.00 on a tick, the block SHALL set O_RUN=0 and O_DONE=1 in the same update.
REQ-022 A start pulse in down mode with O_TIME=00:00.00 SHALL be ignored, leaving O_RUN=0.
REQ-023 O_RUN SHALL change on the clock edge that samples I_START_STOP, giving a latency of 1 cycle.
REQ-024 A tick coincident with a stop pulse SHALL still be applied to O_TIME.
REQ-025 A lap pulse while running SHALL write the current registered O_TIME into entry O_LAP_CNT and increment O_LAP_CNT.
REQ-026 When the lap buffer is full, a new lap SHALL be dropped and O_LAP_CNT SHALL remain at P_LAP_DEPTH.
REQ-027 A clear pulse while stopped SHALL load O_TIME with 0 (up mode) or I_PRESET (down mode), zero O_LAP_CNT, and clear O_DONE and O_OVF.
REQ-028 If I_START_STOP and I_LAP_CLR assert in the same cycle, I_START_STOP SHALL take priority and I_LAP_CLR SHALL be ignored.
REQ-029 O_LAP SHALL be registered, valid 1 cycle after I_LAP_SEL changes, and SHALL read 0 for unwritten entries.
REQ-030 Invalid BCD digits in I_PRESET SHALL be loaded unchanged, with no checking or correction.

Reset
REQ-031 RST_N=0 SHALL immediately drive O_TIME=0, O_LAP=0, O_LAP_CNT=0, O_RUN=0, O_DONE=0, O_OVF=0, the prescaler to 0, and all lap entries to 0, with the mode register set to up.
REQ-032 A reset asserted mid-run SHALL discard all state; after release, the block SHALL stay stopped until a start pulse.

Configuration
REQ-033 The lap buffer SHALL be controlled by the macro STOPWATCH_LAP_EN.
REQ-034 With STOPWATCH_LAP_EN defined, the lap buffer SHALL be implemented as specified above.
REQ-035 Without STOPWATCH_LAP_EN, no lap storage SHALL be synthesised, O_LAP and O_LAP_CNT SHALL be tied to 0, and a lap pulse while running SHALL be ignored; clear behaviour SHALL be unchanged.

Verification (bench with P_CLK_HZ=1000, P_TICK_HZ=100, divisor 10)
REQ-036 Reset, then a start pulse, then 100 cycles -> O_TIME=00:00.10 and O_RUN=1; a stop pulse -> O_RUN=0 and O_TIME frozen for 50 cycles.
REQ-037 Preset 59:59.98 in up mode, start, 20 cycles -> O_TIME=00:00.00, O_OVF=1, O_RUN=1.
REQ-038 I_MODE=1, I_PRESET=00:00.05, clear, start, 50 cycles -> O_TIME=00:00.00, O_RUN=0, O_DONE=1; a further start is ignored.
REQ-039 Running, 5 lap pulses 30 cycles apart with P_LAP_DEPTH=4 -> O_LAP_CNT=4, entries 00:00.03/06/09/12 (±1 tick alignment checked exactly), fifth lap dropped.
REQ-040 Simultaneous I_START_STOP and I_LAP_CLR while running -> stopped, O_LAP_CNT unchanged.
REQ-041 RST_N asserted asynchronously mid-run between clock edges -> all outputs 0 immediately; same run repeated without STOPWATCH_LAP_EN -> O_LAP=0 and O_LAP_CNT=0 throughout.
